// File: rtl/addr_trace_player.sv
// Purpose : address-stream source for the compressed cache; replays a trace held in an
//           internal RAM (once or looped) or generates a base+stride sequence.
// Latency : first addr_valid on the 2nd rising edge after start; sustained 1 address/cycle.
// Backpr. : while addr_valid & !addr_ready, addr_out/addr_valid hold; the next RAM read
//           is simply not issued, so nothing is lost or duplicated.
//
// Ports
//   clock, reset        single rising-edge clock, synchronous active-high reset
//   start, stop         run control (start accepted only in IDLE/DONE, stop aborts RUN)
//   mode                0 replay, 1 stride, 2 loop replay, 3 behaves as replay
//   trace_len           entries per pass, 0..DEPTH
//   base, stride        stride-mode start address and increment
//   wr_en/addr/data     trace RAM load port, honoured only when not running
//   addr_out/valid/rdy  address stream to the cache (valid/ready)
//   busy, done          RUN / DONE state indicators
//   issued_count        handshakes completed in the current run
//
// Optional build macro TRACE_STATS_EN adds hit/resp_valid inputs and saturating
// hit_count/miss_count outputs. Without it those ports do not exist.

module addr_trace_player #(
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 1024,
    parameter int PTR_W  = 10,
    parameter int CNT_W  = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic [1:0]        mode,
    input  logic [PTR_W:0]    trace_len,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] stride,
    input  logic              wr_en,
    input  logic [PTR_W-1:0]  wr_addr,
    input  logic [ADDR_W-1:0] wr_data,
    output logic [ADDR_W-1:0] addr_out,
    output logic              addr_valid,
    input  logic              addr_ready,
    output logic              busy,
    output logic              done,
`ifdef TRACE_STATS_EN
    input  logic              hit,
    input  logic              resp_valid,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count,
`endif
    output logic [CNT_W-1:0]  issued_count
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [1:0] MODE_REPLAY = 2'd0;
    localparam logic [1:0] MODE_STRIDE = 2'd1;
    localparam logic [1:0] MODE_LOOP   = 2'd2;

    localparam logic [PTR_W:0] PTR_ONE = (PTR_W+1)'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]        state_q,    state_d;
    logic [1:0]        mode_q,     mode_d;
    logic [PTR_W:0]    len_q,      len_d;
    logic [ADDR_W-1:0] stride_q,   stride_d;
    logic [ADDR_W-1:0] nxt_addr_q, nxt_addr_d;   // next stride address to present
    logic [ADDR_W-1:0] str_addr_q, str_addr_d;   // stride address currently presented
    logic [PTR_W:0]    fetch_q,    fetch_d;      // index of the next entry to fetch
    logic              vld_q,      vld_d;
    logic [CNT_W-1:0]  issued_q,   issued_d;
`ifdef TRACE_STATS_EN
    logic [CNT_W-1:0]  hit_cnt_q,  hit_cnt_d;
    logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;
`endif

    // Trace RAM with a registered read port. The read register doubles as the
    // output register in replay modes, which is what makes the 2-edge latency.
    logic [ADDR_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] ram_rdat_q;
    logic              ram_we;
    logic              rd_en;
    logic [PTR_W-1:0]  rd_idx;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    logic start_ok;
    logic hs;
    logic adv;
    logic more;

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        len_d      = len_q;
        stride_d   = stride_q;
        nxt_addr_d = nxt_addr_q;
        str_addr_d = str_addr_q;
        fetch_d    = fetch_q;
        vld_d      = vld_q;
        issued_d   = issued_q;
        ram_we     = 1'b0;
        rd_en      = 1'b0;
        rd_idx     = fetch_q[PTR_W-1:0];

        start_ok = start && (state_q != ST_RUN);
        // stop wins over a handshake presented in the same cycle
        hs   = (state_q == ST_RUN) && vld_q && addr_ready && !stop;
        // output slot is free or is being emptied this cycle
        adv  = (state_q == ST_RUN) && !stop && (!vld_q || addr_ready);
        // loop mode always has another entry; len 0 never reaches RUN
        more = (mode_q == MODE_LOOP) || (fetch_q < len_q);

        case (state_q)
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_DONE;
                    vld_d   = 1'b0;
                end else begin
                    if (hs) begin
                        issued_d = issued_q + CNT_ONE;
                    end
                    if (adv) begin
                        if (more) begin
                            vld_d = 1'b1;
                            if (mode_q == MODE_STRIDE) begin
                                str_addr_d = nxt_addr_q;
                                nxt_addr_d = nxt_addr_q + stride_q;
                            end else begin
                                rd_en = 1'b1;
                            end
                            if ((mode_q == MODE_LOOP) && (fetch_q == len_q - PTR_ONE)) begin
                                fetch_d = '0;
                            end else begin
                                fetch_d = fetch_q + PTR_ONE;
                            end
                        end else begin
                            // last entry just handshaken (or slot empty with nothing left)
                            vld_d   = 1'b0;
                            state_d = ST_DONE;
                        end
                    end
                end
            end
            ST_IDLE, ST_DONE: begin
                ram_we = wr_en;
                if (start_ok) begin
                    mode_d     = (mode == 2'd3) ? MODE_REPLAY : mode;
                    len_d      = trace_len;
                    stride_d   = stride;
                    nxt_addr_d = base;
                    fetch_d    = '0;
                    vld_d      = 1'b0;
                    issued_d   = '0;
                    state_d    = (trace_len == '0) ? ST_DONE : ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
                vld_d   = 1'b0;
            end
        endcase
    end

`ifdef TRACE_STATS_EN
    // A response arriving on the same edge as a new start belongs to the old
    // run, so the clear takes priority.
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (start_ok) begin
            hit_cnt_d  = '0;
            miss_cnt_d = '0;
        end else if (resp_valid) begin
            if (hit) begin
                if (!(&hit_cnt_q)) begin
                    hit_cnt_d = hit_cnt_q + CNT_ONE;
                end
            end else begin
                if (!(&miss_cnt_q)) begin
                    miss_cnt_d = miss_cnt_q + CNT_ONE;
                end
            end
        end
    end
`endif

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            mode_q     <= MODE_REPLAY;
            len_q      <= '0;
            stride_q   <= '0;
            nxt_addr_q <= '0;
            str_addr_q <= '0;
            fetch_q    <= '0;
            vld_q      <= 1'b0;
            issued_q   <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            len_q      <= len_d;
            stride_q   <= stride_d;
            nxt_addr_q <= nxt_addr_d;
            str_addr_q <= str_addr_d;
            fetch_q    <= fetch_d;
            vld_q      <= vld_d;
            issued_q   <= issued_d;
        end
    end

`ifdef TRACE_STATS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end
`endif

    // RAM array has no reset so its contents survive reset.
    always_ff @(posedge clock) begin
        if (ram_we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read register is reset so addr_out reads 0 out of reset. Writes and
    // reads never overlap (writes only outside RUN); if they did, the
    // non-blocking update would still return the old word.
    always_ff @(posedge clock) begin
        if (reset) begin
            ram_rdat_q <= '0;
        end else if (rd_en) begin
            ram_rdat_q <= mem[rd_idx];
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign addr_out     = (mode_q == MODE_STRIDE) ? str_addr_q : ram_rdat_q;
    assign addr_valid   = vld_q;
    assign busy         = (state_q == ST_RUN);
    assign done         = (state_q == ST_DONE);
    assign issued_count = issued_q;
`ifdef TRACE_STATS_EN
    assign hit_count    = hit_cnt_q;
    assign miss_count   = miss_cnt_q;
`endif

endmodule

// File: tb/tb_addr_trace_player.sv
// Directed bench for addr_trace_player: replay, stall hold, stride wrap,
// loop + stop, reset mid-run, zero-length start, and RAM write protection.
module tb_addr_trace_player;

    localparam int PTR_W = 10;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              stop  = 1'b0;
    logic [1:0]        mode  = 2'd0;
    logic [PTR_W:0]    trace_len = '0;
    logic [31:0]       base   = '0;
    logic [31:0]       stride = '0;
    logic              wr_en  = 1'b0;
    logic [PTR_W-1:0]  wr_addr = '0;
    logic [31:0]       wr_data = '0;
    logic [31:0]       addr_out;
    logic              addr_valid;
    logic              addr_ready = 1'b0;
    logic              busy;
    logic              done;
    logic [31:0]       issued_count;
`ifdef TRACE_STATS_EN
    logic              hit = 1'b0;
    logic              resp_valid = 1'b0;
    logic [31:0]       hit_count;
    logic [31:0]       miss_count;
`endif

    always #5 clock = ~clock;

    addr_trace_player #(
        .ADDR_W(32), .DEPTH(1024), .PTR_W(PTR_W), .CNT_W(32)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .stop         (stop),
        .mode         (mode),
        .trace_len    (trace_len),
        .base         (base),
        .stride       (stride),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .addr_out     (addr_out),
        .addr_valid   (addr_valid),
        .addr_ready   (addr_ready),
        .busy         (busy),
        .done         (done),
`ifdef TRACE_STATS_EN
        .hit          (hit),
        .resp_valid   (resp_valid),
        .hit_count    (hit_count),
        .miss_count   (miss_count),
`endif
        .issued_count (issued_count)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic        rdy_pat [0:15];
    logic [31:0] got     [0:15];
    int          n_got;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // advance one edge; inputs are driven and outputs sampled 1ns after it
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic ram_wr(input int a, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_addr = a[PTR_W-1:0];
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic kick(input logic [1:0] m, input int len, input logic [31:0] b, input logic [31:0] s);
        mode      = m;
        trace_len = len[PTR_W:0];
        base      = b;
        stride    = s;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic all_ready();
        for (int i = 0; i < 16; i++) rdy_pat[i] = 1'b1;
    endtask

    // Drive addr_ready from rdy_pat, record accepted addresses, check that a
    // stalled address holds, and stop once done rises (bounded by budget).
    task automatic collect(input int budget);
        logic        stall;
        logic [31:0] last;
        int          c;
        n_got = 0;
        stall = 1'b0;
        last  = '0;
        c     = 0;
        while (!done && c < budget) begin
            addr_ready = rdy_pat[c % 16];
            if (stall) begin
                chk("hold_addr", addr_out, last);
                chk("hold_vld", addr_valid, 1);
            end
            if (addr_valid && addr_ready) begin
                if (n_got < 16) got[n_got] = addr_out;
                n_got++;
            end
            stall = addr_valid && !addr_ready;
            last  = addr_out;
            tick();
            c++;
        end
        chk("collect_done", done, 1);
        addr_ready = 1'b0;
    endtask

    task automatic expect_seq(input string tag, input int n,
                              input logic [31:0] e0, input logic [31:0] e1,
                              input logic [31:0] e2, input logic [31:0] e3);
        logic [31:0] e [4];
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        chk({tag, "_count"}, n_got, n);
        for (int i = 0; i < n && i < n_got; i++) begin
            chk($sformatf("%s_%0d", tag, i), got[i], e[i]);
        end
    endtask

    initial begin
        all_ready();

        // ---------------- reset state ----------------
        tick();
        tick();
        chk("rst_addr", addr_out, 0);
        chk("rst_vld", addr_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cnt", issued_count, 0);
        reset = 1'b0;

        ram_wr(0, 32'd10);
        ram_wr(1, 32'd20);
        ram_wr(2, 32'd30);
        ram_wr(3, 32'd40);

        // ---------------- replay, ready held high ----------------
        addr_ready = 1'b1;
        kick(2'd0, 4, 0, 0);
        chk("t1_busy", busy, 1);
        chk("t1_lat_vld", addr_valid, 0);
        tick();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t1_vld_%0d", k), addr_valid, 1);
            chk($sformatf("t1_addr_%0d", k), addr_out, 10 * (k + 1));
            tick();
        end
        chk("t1_done", done, 1);
        chk("t1_busy_end", busy, 0);
        chk("t1_vld_end", addr_valid, 0);
        chk("t1_cnt", issued_count, 4);

        // ---------------- replay with ready 1,0,0,1 ----------------
        addr_ready = 1'b0;
        rdy_pat[2] = 1'b0;
        rdy_pat[3] = 1'b0;
        kick(2'd0, 4, 0, 0);
        chk("t2_done_cleared", done, 0);
        collect(50);
        expect_seq("t2", 4, 32'd10, 32'd20, 32'd30, 32'd40);
        chk("t2_cnt", issued_count, 4);
        all_ready();

        // ---------------- reset mid-run ----------------
        addr_ready = 1'b1;
        kick(2'd0, 4, 0, 0);
        tick();
        tick();
        tick();
        chk("t5_cnt_mid", issued_count, 2);
        chk("t5_addr_mid", addr_out, 30);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t5_rst_addr", addr_out, 0);
        chk("t5_rst_vld", addr_valid, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_done", done, 0);
        chk("t5_rst_cnt", issued_count, 0);
        addr_ready = 1'b0;
        kick(2'd0, 4, 0, 0);
        collect(50);
        expect_seq("t5_restart", 4, 32'd10, 32'd20, 32'd30, 32'd40);

        // ---------------- zero-length start from IDLE ----------------
        reset = 1'b1;
        tick();
        reset = 1'b0;
        addr_ready = 1'b1;
        kick(2'd0, 0, 0, 0);
        chk("t6_done", done, 1);
        chk("t6_busy", busy, 0);
        chk("t6_vld", addr_valid, 0);
        chk("t6_cnt", issued_count, 0);
        tick();
        chk("t6_vld_later", addr_valid, 0);
        addr_ready = 1'b0;

        // ---------------- RAM write ignored while running ----------------
        kick(2'd0, 4, 0, 0);
        wr_en   = 1'b1;
        wr_addr = 10'd1;
        wr_data = 32'hDEAD;
        tick();
        wr_en   = 1'b0;
        chk("t7_busy", busy, 1);
        collect(50);
        expect_seq("t7_run", 4, 32'd10, 32'd20, 32'd30, 32'd40);
        kick(2'd0, 4, 0, 0);
        collect(50);
        expect_seq("t7_next", 4, 32'd10, 32'd20, 32'd30, 32'd40);

        // ---------------- reserved mode behaves as replay ----------------
        kick(2'd3, 2, 0, 0);
        collect(50);
        expect_seq("mode3", 2, 32'd10, 32'd20, 0, 0);

        // ---------------- stride with address wrap ----------------
        kick(2'd1, 3, 32'hFFFF_FFF8, 32'd4);
        collect(50);
        expect_seq("t3", 3, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 0);
        chk("t3_cnt", issued_count, 3);

        // ---------------- loop replay then stop ----------------
        ram_wr(0, 32'hA);
        ram_wr(1, 32'hB);
        addr_ready = 1'b1;
        kick(2'd2, 2, 0, 0);
        tick();
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("t4_vld_%0d", k), addr_valid, 1);
            chk($sformatf("t4_addr_%0d", k), addr_out, (k % 2 == 0) ? 32'hA : 32'hB);
            tick();
        end
        chk("t4_cnt5", issued_count, 5);
        chk("t4_still_busy", busy, 1);
        // stop with ready still high: the pending handshake must not count
        stop = 1'b1;
        tick();
        stop = 1'b0;
        addr_ready = 1'b0;
        chk("t4_stop_vld", addr_valid, 0);
        chk("t4_stop_done", done, 1);
        chk("t4_stop_busy", busy, 0);
        chk("t4_stop_cnt", issued_count, 5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
